// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_unit
//  Description : Instruction-fetch stage for the 5-stage pipeline. Owns the
//                fetch PC, drives instruction memory, forwards the fetched
//                word to IF/ID and resolves jr / jump / branch redirects
//                from EX, squashing the two younger in-flight instructions.
//  Revision    : 1.0  initial release
// ============================================================================
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] Instructions,
    input  logic        br_taken,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] seOut,
    input  logic [31:0] reg_Da,
    output logic        squash,
    output logic [31:0] pc_plus4_ex,
    output logic        misalign
);

    localparam logic [31:0] c_pc_step = 32'd4;

    // Fetch PC and the IF/ID, ID/EX shadows of PC and instruction word.
    // The shadows let the jump target and link value be formed here
    // without reaching back into the datapath.
    logic [31:0] r_pc;
    logic [31:0] r_pc_id;
    logic [31:0] r_instr_id;
    logic [31:0] r_pc_ex;
    logic [31:0] r_instr_ex;

    logic        w_redirect;
    logic [31:0] w_pc_plus4_ex;
    logic [31:0] w_jr_target;
    logic [31:0] w_jump_target;
    logic [31:0] w_branch_target;
    logic [31:0] w_target;
    logic [31:0] w_fetch_word;

    // Opcode bits of the EX instruction are decoded by control, not here.
    logic        w_unused;
    assign w_unused = &{1'b0, r_instr_ex[31:26]};

    assign w_redirect    = jr | jump | br_taken;
    assign w_pc_plus4_ex = r_pc_ex + c_pc_step;

    // Register targets are forced word-aligned; misalignment is only flagged.
    assign w_jr_target     = {reg_Da[31:2], 2'b00};
    assign w_jump_target   = {w_pc_plus4_ex[31:28], r_instr_ex[25:0], 2'b00};
    assign w_branch_target = w_pc_plus4_ex + (seOut << 2);

    // Redirect target selection, jr has highest priority, then jump, then branch.
    always_comb begin
        w_target = w_branch_target;
        if (jr) begin
            w_target = w_jr_target;
        end else if (jump) begin
            w_target = w_jump_target;
        end
    end

    // The word fetched in a redirect cycle is on the wrong path: replace it.
    assign w_fetch_word = w_redirect ? NOP_WORD : imem_data;

    assign imem_addr    = r_pc;
    assign Instructions = w_fetch_word;
    assign squash       = w_redirect;
    assign misalign     = jr & (reg_Da[1:0] != 2'b00);
    assign pc_plus4_ex  = w_pc_plus4_ex;

    // PC / pipeline-shadow update: reset > redirect > stall > normal advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_pc_id    <= 32'd0;
            r_instr_id <= NOP_WORD;
            r_pc_ex    <= 32'd0;
            r_instr_ex <= NOP_WORD;
        end else if (w_redirect) begin
            // Both younger instructions become bubbles; redirect beats stall.
            r_pc       <= w_target;
            r_pc_id    <= r_pc;
            r_instr_id <= NOP_WORD;
            r_pc_ex    <= r_pc_id;
            r_instr_ex <= NOP_WORD;
        end else if (stall) begin
            // Hold fetch and IF/ID; push a bubble into EX.
            r_instr_ex <= NOP_WORD;
        end else begin
            r_pc       <= r_pc + c_pc_step;
            r_pc_id    <= r_pc;
            r_instr_id <= w_fetch_word;
            r_pc_ex    <= r_pc_id;
            r_instr_ex <= r_instr_id;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifetch_unit
//  Description : Scoreboard bench for ifetch_unit. A driver issues directed
//                and random cycles, a reference model of the fetch pipeline
//                predicts the outputs into a queue, and a monitor compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ifetch_unit;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;
    localparam logic [31:0] c_nop      = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] Instructions;
    logic        br_taken = 1'b0;
    logic        jump = 1'b0;
    logic        jr = 1'b0;
    logic [31:0] seOut = 32'd0;
    logic [31:0] reg_Da = 32'd0;
    logic        squash;
    logic [31:0] pc_plus4_ex;
    logic        misalign;

    ifetch_unit #(
        .RESET_PC (c_reset_pc),
        .NOP_WORD (c_nop)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .Instructions (Instructions),
        .br_taken     (br_taken),
        .jump         (jump),
        .jr           (jr),
        .seOut        (seOut),
        .reg_Da       (reg_Da),
        .squash       (squash),
        .pc_plus4_ex  (pc_plus4_ex),
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    // Instruction memory: low addresses return their own address, one word
    // is a J with target field 0x40, the rest is a scrambled pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h1000_0008) return 32'h0800_0040;
        if (a < 32'h0000_0100) return a;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    endfunction

    assign imem_data = mem_word(imem_addr);

    // One in-flight instruction slot of the reference model.
    typedef struct {
        bit          valid;     // real instruction (not bubble / reset NOP)
        bit          pc_known;  // its PC is defined by the pipeline rules
        logic [31:0] pc;
        logic [31:0] instr;
    } slot_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        squash;
        logic        misalign;
        logic [31:0] pp4;
        bit          pp4_known;
    } exp_t;

    slot_t       m_id;
    slot_t       m_ex;
    logic [31:0] m_pc;
    bit          m_init = 1'b0;
    exp_t        q[$];

    int checks   = 0;
    int failures = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, predict outputs, then advance the model.
    task automatic cycle(input bit r, input bit st, input bit b, input bit j,
                         input bit jrv, input logic [31:0] se, input logic [31:0] rd);
        exp_t        e;
        bit          redir;
        logic [31:0] link;
        logic [31:0] tgt;
        rst = r; stall = st; br_taken = b; jump = j; jr = jrv; seOut = se; reg_Da = rd;
        redir = b | j | jrv;
        link  = m_ex.pc + 32'd4;
        if (jrv)    tgt = rd & ~32'd3;
        else if (j) tgt = (link & 32'hF000_0000) | ((m_ex.instr & 32'h03FF_FFFF) * 32'd4);
        else        tgt = link + se * 32'd4;
        if (m_init) begin
            e.addr      = m_pc;
            e.instr     = redir ? c_nop : mem_word(m_pc);
            e.squash    = redir;
            e.misalign  = jrv && (rd % 4 != 0);
            e.pp4       = link;
            e.pp4_known = m_ex.pc_known;
            q.push_back(e);
        end
        @(posedge clk);
        if (r) begin
            m_pc   = c_reset_pc;
            m_id   = '{1'b0, 1'b1, 32'd0, c_nop};
            m_ex   = '{1'b0, 1'b1, 32'd0, c_nop};
            m_init = 1'b1;
        end else if (redir) begin
            m_pc = tgt;
            m_id = '{1'b0, 1'b0, 32'd0, c_nop};
            m_ex = '{1'b0, 1'b0, 32'd0, c_nop};
        end else if (st) begin
            m_ex.valid = 1'b0;
            m_ex.instr = c_nop;
        end else begin
            m_ex = m_id;
            m_id = '{1'b1, 1'b1, m_pc, mem_word(m_pc)};
            m_pc = m_pc + 32'd4;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 32'd0, 32'd0);
    endtask

    // Advance until EX holds a real instruction at the requested PC (any PC if want_any).
    task automatic run_to_ex(input bit want_any, input logic [31:0] pc);
        int n = 0;
        while (!(m_ex.valid && (want_any || m_ex.pc == pc)) && n < 32) begin
            idle(1);
            n++;
        end
        if (!(m_ex.valid && (want_any || m_ex.pc == pc))) begin
            failures++;
            $display("FAIL run_to_ex: EX slot not reached, got pc %h expected %h", m_ex.pc, pc);
        end
    endtask

    // Monitor: compare every presented cycle against the predicted response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check32("imem_addr", imem_addr, e.addr);
                check32("Instructions", Instructions, e.instr);
                check32("squash", {31'd0, squash}, {31'd0, e.squash});
                check32("misalign", {31'd0, misalign}, {31'd0, e.misalign});
                if (e.pp4_known) check32("pc_plus4_ex", pc_plus4_ex, e.pp4);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          r, st, b, j, jrv;
        logic [2:0]  k;
        logic [31:0] se;
        @(posedge clk); #1;

        // Reset, then four sequential fetches 0,4,8,12.
        cycle(1, 0, 0, 0, 0, 32'd0, 32'd0);
        idle(4);
        // Branch with EX at 0x10, seOut=3 -> 0x20.
        run_to_ex(0, 32'h10);
        cycle(0, 0, 1, 0, 0, 32'd3, 32'd0);
        idle(2);
        // jr and jump together: jr wins -> 0x400.
        run_to_ex(1, 32'd0);
        cycle(0, 0, 0, 1, 1, 32'd0, 32'h400);
        // jump from pc_ex 0x1000_0008 with target field 0x40 -> 0x1000_0100.
        run_to_ex(1, 32'd0);
        cycle(0, 0, 0, 0, 1, 32'd0, 32'h1000_0000);
        run_to_ex(0, 32'h1000_0008);
        cycle(0, 0, 0, 1, 0, 32'd0, 32'd0);
        // Misaligned jr -> 0x120, misalign pulses once.
        run_to_ex(1, 32'd0);
        cycle(0, 0, 0, 0, 1, 32'd0, 32'h123);
        idle(2);
        // Three-cycle stall at PC 0x8, release, then stall together with branch.
        cycle(1, 0, 0, 0, 0, 32'd0, 32'd0);
        idle(2);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 32'd0, 32'd0);
        idle(2);
        run_to_ex(1, 32'd0);
        cycle(0, 1, 1, 0, 0, 32'hFFFF_FFFE, 32'd0);
        idle(2);
        // PC wrap from 0xFFFF_FFFC, then reset during a redirect.
        run_to_ex(1, 32'd0);
        cycle(0, 0, 0, 0, 1, 32'd0, 32'hFFFF_FFFC);
        idle(3);
        run_to_ex(1, 32'd0);
        cycle(1, 0, 0, 0, 1, 32'd0, 32'h0000_0800);
        idle(3);

        // Random traffic; redirects only when EX holds a real instruction.
        for (int i = 0; i < 2000; i++) begin
            r  = ($urandom_range(0, 63) == 0);
            st = ($urandom_range(0, 3) == 0);
            b = 0; j = 0; jrv = 0;
            if (m_ex.valid && $urandom_range(0, 3) == 0) begin
                k   = 3'($urandom_range(1, 7));
                b   = k[0];
                j   = k[1];
                jrv = k[2];
            end
            se = 32'($urandom_range(0, 63));
            se = se - 32'd32;
            if ($urandom_range(0, 3) == 0) se = $urandom;
            cycle(r, st, b, j, jrv, se, $urandom);
        end

        cycle(0, 0, 0, 0, 0, 32'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check32("queue_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
